// File: rtl/weight_load_sched.sv
// Weight-bank load sequencer: pulls weights from a valid/ready stream and writes
// them one bank at a time into clock-gated registers over a shared weight bus.
module weight_load_sched #(
  parameter int NUM_BANKS = 8,
  parameter int WEIGHT_W  = 36,
  parameter int IDX_W     = $clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [NUM_BANKS-1:0] i_bank_mask,
  input  logic                 i_abort,
  input  logic                 i_valid,
  input  logic [WEIGHT_W-1:0]  i_weight,
  output logic                 o_ready,
  output logic [WEIGHT_W-1:0]  o_weight,
  output logic [NUM_BANKS-1:0] o_en,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [NUM_BANKS-1:0] o_loaded
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WRITE, S_HOLD, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_BANKS-1:0] r_mask;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_abort_pend;
  logic [WEIGHT_W-1:0]  r_weight;
  logic [NUM_BANKS-1:0] r_en, r_loaded;
  logic                 r_ready, r_busy, r_done;

  logic [IDX_W-1:0]     w_first_idx, w_nxt_idx;
  logic                 w_nxt_vld;
  logic [NUM_BANKS-1:0] w_onehot;

  // Descending loops so the lowest qualifying bit is the last one assigned.
  always_comb begin
    w_first_idx = '0;
    w_nxt_idx   = '0;
    w_nxt_vld   = 1'b0;
    w_onehot    = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (i_bank_mask[i]) w_first_idx = IDX_W'(i);
      if (r_mask[i] && (i > int'(r_idx))) begin
        w_nxt_idx = IDX_W'(i);
        w_nxt_vld = 1'b1;
      end
      w_onehot[i] = (r_idx == IDX_W'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = (i_bank_mask == '0) ? S_DONE : S_FETCH;
      S_FETCH: if (i_abort) w_state_nxt = S_IDLE;
               else if (i_valid) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = S_HOLD;
      S_HOLD:  if (r_abort_pend || i_abort) w_state_nxt = S_IDLE;
               else w_state_nxt = w_nxt_vld ? S_FETCH : S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mask       <= '0;
      r_idx        <= '0;
      r_abort_pend <= 1'b0;
      r_weight     <= '0;
      r_en         <= '0;
      r_loaded     <= '0;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == S_FETCH);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
      r_en    <= (w_state_nxt == S_WRITE) ? w_onehot : '0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_mask       <= i_bank_mask;
          r_loaded     <= '0;
          r_idx        <= w_first_idx;
          r_abort_pend <= 1'b0;
        end
        S_FETCH: if (i_valid && !i_abort) r_weight <= i_weight;
        S_WRITE: begin
          r_loaded <= r_loaded | w_onehot;
          if (i_abort) r_abort_pend <= 1'b1;
        end
        S_HOLD: if (w_state_nxt == S_FETCH) r_idx <= w_nxt_idx;
        default: ;
      endcase
    end
  end

  assign o_ready  = r_ready;
  assign o_weight = r_weight;
  assign o_en     = r_en;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_loaded = r_loaded;

endmodule

// File: doc/weight_load_sched.md
Name: weight_load_sched

Overview:
Sequencer that loads a bank of clock-gated 36-bit weight registers in the SD4 MAC array, one bank per transaction. It accepts weights from an upstream valid/ready stream and broadcasts each one on a shared weight bus. It issues a one-hot, single-cycle enable to the target gated register and holds the bus stable past the gated capture edge. Banks not selected by a load mask are skipped; completion is reported to the MAC control.

Parameters:
NUM_BANKS, 8, number of gated weight registers driven (2..16)
WEIGHT_W, 36, weight bus width
IDX_W, 3, bank index width, equal to clog2(NUM_BANKS)

Ports:
clk  in  1  single system clock, rising-edge
rst_n  in  1  synchronous active-low reset
i_start  in  1  start a load pass; sampled only in IDLE
i_bank_mask  in  NUM_BANKS  banks to load this pass; latched on accepted i_start
i_abort  in  1  cancel the pass
i_valid  in  1  upstream weight valid
i_weight  in  WEIGHT_W  upstream weight data
o_ready  out  1  upstream ready
o_weight  out  WEIGHT_W  shared weight bus to all gated registers
o_en  out  NUM_BANKS  one-hot per-bank gate enable
o_busy  out  1  pass in progress (any state other than IDLE)
o_done  out  1  one-cycle pulse at normal completion
o_loaded  out  NUM_BANKS  banks written this pass

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, named rst_n. When rst_n=0 at a rising edge: state=IDLE, all outputs 0, latched mask=0, idx=0.
- All outputs are registered. o_ready is high only in FETCH.
- Gated-register timing: a gated register latches its enable on the falling edge of clk and captures on the next rising edge. o_en is therefore high for exactly one cycle (WRITE). o_weight must stay unchanged through WRITE and the following HOLD cycle.
- States:
  - IDLE: on i_start=1, latch mask and clear o_loaded.
    - mask=0: go to DONE.
    - otherwise: idx = lowest set bit of mask; go to FETCH.
  - FETCH: o_ready=1. On i_valid=1 (a handshake), register i_weight into o_weight and go to WRITE. Otherwise stay.
  - WRITE: o_en = 1<<idx for one cycle; go to HOLD.
  - HOLD: o_en=0, o_weight held, set o_loaded[idx].
    - Next set mask bit above idx exists: idx = that bit; go to FETCH.
    - None left: go to DONE.
  - DONE: o_done=1 for one cycle; go to IDLE. o_loaded is retained until the next accepted i_start.
- Throughput: 3 cycles per bank minimum (FETCH with i_valid already high, WRITE, HOLD). i_valid may be held high; exactly one weight is consumed per FETCH.
- Abort:
  - In FETCH: go to IDLE next cycle. No handshake that cycle, even if i_valid=1. No o_done.
  - In WRITE or HOLD: the current bank completes normally (the enable is never truncated), then go to IDLE instead of FETCH/DONE. No o_done.
  - In IDLE or DONE: ignored.
  - In all cases o_loaded keeps the banks already written.
- i_start outside IDLE is ignored, and i_bank_mask is not re-sampled.
- Simultaneous i_start and i_abort in IDLE: the start wins.
- Mask bits at or above NUM_BANKS do not exist. idx never wraps; the scan is strictly ascending.
- o_en is never multi-hot and never high outside WRITE.
- o_weight is unchanged in IDLE/DONE and keeps the last written weight.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with i_start=1 and i_valid=1 -> all outputs 0, state IDLE; release -> still idle until i_start.
- Full pass: mask=8'hFF, i_valid held high, weights 36'h0_0000_0001..36'h0_0000_0008 -> o_en=8'h01,8'h02,...,8'h80, one every 3 cycles. o_weight equals the matching weight during each WRITE and the following HOLD. o_done pulses 25 cycles after start. o_loaded=8'hFF.
- Sparse mask with backpressure: mask=8'b1010_0100, i_valid low 4 cycles in each FETCH -> only o_en bits 2, 5, 7 fire, in that order. o_ready is high only in FETCH. o_loaded=8'hA4.
- Empty mask: i_start with mask=0 -> o_busy for 1 cycle, o_done pulse in cycle 2, o_en never asserted, o_loaded=0.
- Abort cases, mask=8'h0F:
  - i_abort during the WRITE of bank 1 -> bank 1 HOLD completes, o_loaded=8'h03, IDLE, no o_done.
  - i_abort in FETCH with i_valid=1 -> no handshake, IDLE next cycle.
- Start while busy: pulse i_start with mask=8'hF0 mid-pass of mask=8'h03 -> ignored; only banks 0 and 1 written; the following start in IDLE loads banks 4..7.
